delay_line_bank: RTL and testbench

Parametrised, fully synchronous successor to the two-line LVDC delay-line memory. It holds CHANNELS circulating serial lines of DEPTH bit-times each, with write-gate injection and per-channel erase. It also has a PHASES-way sample-latch array that captures each line's emerging bit on its phase, replacing the per-bit W/X/Y/Z latch pairs. After reset, a self-clear sweep leaves every line deterministically zero before it starts circulating.

---
 rtl/delay_line_bank_if.sv | 33 +++
 rtl/delay_line_bank.sv | 94 +++++++++
 tb/tb_delay_line_bank.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/delay_line_bank_if.sv
// Signal bundle for delay_line_bank: line-control inputs and observed outputs.
// bit_en is a strobe without backpressure; it advances the lines only while ready is high and is dropped otherwise.
interface delay_line_bank_if #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 64,
  parameter int PHASES   = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic                         bit_en;
  logic [CHANNELS-1:0]          wr_gate;
  logic [CHANNELS-1:0]          wr_data;
  logic [CHANNELS-1:0]          erase;
  logic                         ready;
  logic [CHANNELS-1:0]          line_out;
  logic [PW-1:0]                phase;
  logic [AW-1:0]                bit_pos;
  logic                         wrap;
  logic [CHANNELS*PHASES-1:0]   sample;
  logic [CHANNELS*PHASES-1:0]   sample_n;
  logic                         dbg_state;

  modport master (
    output bit_en, wr_gate, wr_data, erase,
    input  ready, line_out, phase, bit_pos, wrap, sample, sample_n, dbg_state
  );

  modport slave (
    input  bit_en, wr_gate, wr_data, erase,
    output ready, line_out, phase, bit_pos, wrap, sample, sample_n, dbg_state
  );
endinterface

// File: rtl/delay_line_bank.sv
// Bank of circulating serial delay lines with write-gate injection, erase and a
// per-phase sample-latch array; a post-reset sweep zeroes every line before RUN.
module delay_line_bank #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 64,
  parameter int PHASES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  delay_line_bank_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [AW-1:0]               r_clr;
  logic [AW-1:0]               r_pos;
  logic [PW-1:0]               r_phase;
  logic [CHANNELS-1:0]         r_mem [DEPTH];
  logic [CHANNELS-1:0]         r_line_out;
  logic [CHANNELS*PHASES-1:0]  r_sample;
  logic                        r_wrap;
  logic                        w_adv;
  logic                        w_pos_last;
  logic [CHANNELS-1:0]         w_out;
  logic [CHANNELS-1:0]         w_new;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_clr == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_adv      = (r_state == ST_RUN) && bus.bit_en;
  assign w_pos_last = (r_pos == AW'(DEPTH - 1));
  assign w_out      = r_mem[r_pos];

  // Write gate beats erase, erase beats recirculation.
  always_comb begin
    w_new = w_out;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (bus.wr_gate[ch])    w_new[ch] = bus.wr_data[ch];
      else if (bus.erase[ch]) w_new[ch] = 1'b0;
    end
  end

  // Storage has no reset; the INIT sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_mem[r_clr] <= '0;
    else if (w_adv)         r_mem[r_pos] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_clr      <= '0;
      r_pos      <= '0;
      r_phase    <= '0;
      r_line_out <= '0;
      r_sample   <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= 1'b0;
      if (r_state == ST_INIT) r_clr <= r_clr + AW'(1);
      if (w_adv) begin
        r_line_out <= w_out;
        for (int ch = 0; ch < CHANNELS; ch++) begin
          for (int p = 0; p < PHASES; p++) begin
            if (r_phase == PW'(p)) r_sample[ch*PHASES+p] <= w_out[ch];
          end
        end
        r_pos   <= w_pos_last ? '0 : r_pos + AW'(1);
        r_wrap  <= w_pos_last;
        r_phase <= (r_phase == PW'(PHASES - 1)) ? '0 : r_phase + PW'(1);
      end
    end
  end

  assign bus.ready     = (r_state == ST_RUN);
  assign bus.line_out  = r_line_out;
  assign bus.phase     = r_phase;
  assign bus.bit_pos   = r_pos;
  assign bus.wrap      = r_wrap;
  assign bus.sample    = r_sample;
  assign bus.sample_n  = ~r_sample;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_delay_line_bank.sv
// Directed bench for delay_line_bank: queue-based line model checked every cycle,
// plus hand-computed expectations at key points.
module tb_delay_line_bank;
  localparam int CH = 2;
  localparam int D  = 64;
  localparam int P  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  delay_line_bank_if #(.CHANNELS(CH), .DEPTH(D), .PHASES(P)) bus ();

  delay_line_bank #(.CHANNELS(CH), .DEPTH(D), .PHASES(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: each line is a FIFO of DEPTH bits; the front is the bit about to emerge.
  bit             mq [CH][$];
  bit             m_ready;
  int             m_init;
  int             m_pulses;
  logic [CH-1:0]  m_line;
  logic [CH*P-1:0] m_sample;
  bit             m_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int ch = 0; ch < CH; ch++) begin
        mq[ch].delete();
        repeat (D) mq[ch].push_back(1'b0);
      end
      m_ready = 1'b0; m_init = 0; m_pulses = 0;
      m_line = '0; m_sample = '0; m_wrap = 1'b0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == D) m_ready = 1'b1;
      m_wrap = 1'b0;
    end else if (bus.bit_en) begin
      for (int ch = 0; ch < CH; ch++) begin
        bit o;
        o = mq[ch].pop_front();
        mq[ch].push_back(bus.wr_gate[ch] ? bus.wr_data[ch] : (bus.erase[ch] ? 1'b0 : o));
        m_line[ch] = o;
        m_sample[ch*P + (m_pulses % P)] = o;
      end
      m_pulses++;
      m_wrap = ((m_pulses % D) == 0);
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic cyc(input bit be, input logic [CH-1:0] wg, input logic [CH-1:0] wd,
                     input logic [CH-1:0] er);
    bus.bit_en  = be;
    bus.wr_gate = wg;
    bus.wr_data = wd;
    bus.erase   = er;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH*P-1:0] exp_n;
      exp_n = ~m_sample;
      check("ready",     bus.ready,     m_ready);
      check("dbg_state", bus.dbg_state, m_ready);
      check("line_out",  bus.line_out,  m_line);
      check("sample",    bus.sample,    m_sample);
      check("sample_n",  bus.sample_n,  exp_n);
      check("phase",     bus.phase,     m_pulses % P);
      check("bit_pos",   bus.bit_pos,   m_pulses % D);
      check("wrap",      bus.wrap,      m_wrap);
    end
  end

  task automatic wait_init(input string tag);
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, '0, '0, '0);
      if (i == D - 2) check({tag, "_ready_lo"}, bus.ready, 0);
      if (i == D - 1) begin
        check({tag, "_ready_hi"}, bus.ready, 1);
        check({tag, "_pos0"}, bus.bit_pos, 0);
        check({tag, "_phase0"}, bus.phase, 0);
      end
    end
  endtask

  logic [3:0] pat;
  int ones0, ones1, wraps;

  initial begin
    pat = 4'b1101;
    bus.bit_en = 1'b0; bus.wr_gate = '0; bus.wr_data = '0; bus.erase = '0;
    reset = 1'b1;
    cyc(1'b0, '0, '0, '0);
    chk_en = 1'b1;
    cyc(1'b0, '0, '0, '0);
    check("rst_ready",    bus.ready,    0);
    check("rst_sample",   bus.sample,   0);
    check("rst_sample_n", bus.sample_n, 32'hFF);
    check("rst_line",     bus.line_out, 0);
    reset = 1'b0;

    // INIT with bit_en held high: strobes must be ignored.
    wait_init("init");

    // Single 1 injected on ch0 at bit_pos 5; recurs every D pulses.
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 3*D; k++) begin
      cyc(1'b1, (k == 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, '0);
      ones0 += int'(bus.line_out[0]);
      ones1 += int'(bus.line_out[1]);
      if (k == 5 + D || k == 5 + 2*D) check("recirc_one", bus.line_out, 2'b01);
      if (k == 6 + D) check("recirc_next0", bus.line_out, 2'b00);
    end
    check("recirc_ones_ch0", ones0, 2);
    check("recirc_ones_ch1", ones1, 0);

    // Erase ch0 for one pass; the pass after must be silent.
    for (int k = 0; k < D; k++) cyc(1'b1, '0, '0, 2'b01);
    ones0 = 0;
    for (int k = 0; k < D; k++) begin
      cyc(1'b1, '0, '0, '0);
      ones0 += int'(bus.line_out[0]);
    end
    check("erase_silent", ones0, 0);

    // Write gate and erase together at pos 10: the written 1 survives.
    ones0 = 0;
    for (int k = 0; k < 2*D; k++) begin
      cyc(1'b1, (k == 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00,
          (k < D) ? 2'b01 : 2'b00);
      ones0 += int'(bus.line_out[0]);
      if (k == 10 + D) check("wr_over_erase", bus.line_out, 2'b01);
    end
    check("wr_over_erase_ones", ones0, 1);

    // Phase pattern 1,0,1,1 on ch0 (phase p holds pat[p]); pass starts at phase 0.
    for (int k = 0; k < D; k++) cyc(1'b1, 2'b01, {1'b0, pat[k % P]}, '0);
    for (int k = 0; k < D; k++) begin
      cyc(1'b1, '0, '0, '0);
      if (k == 3 || k == 31 || k == D - 1) check("phase_latch", bus.sample, 32'h0D);
    end
    for (int k = 0; k < 10; k++) cyc(1'b0, '0, '0, '0);
    check("latch_hold",   bus.sample,   32'h0D);
    check("latch_hold_n", bus.sample_n, 32'hF2);
    check("gap_wrap",     bus.wrap,     0);

    // Sparse strobes, one in three cycles: two wraps over 2*D pulses.
    wraps = 0;
    for (int c = 0; c < 6*D; c++) begin
      cyc((c % 3) == 0, '0, '0, '0);
      wraps += int'(bus.wrap);
    end
    check("sparse_wraps", wraps, 2);
    check("sparse_pos",   bus.bit_pos, 0);
    check("sparse_phase", bus.phase,   0);

    // Reset mid-circulation, then again part-way through the sweep.
    for (int k = 0; k < 20; k++) cyc(1'b1, '0, '0, '0);
    reset = 1'b1;
    cyc(1'b1, '0, '0, '0);
    reset = 1'b0;
    check("mid_rst_ready",  bus.ready,    0);
    check("mid_rst_pos",    bus.bit_pos,  0);
    check("mid_rst_sample", bus.sample,   0);
    check("mid_rst_line",   bus.line_out, 0);
    for (int k = 0; k < 20; k++) cyc(1'b0, '0, '0, '0);
    reset = 1'b1;
    cyc(1'b0, '0, '0, '0);
    reset = 1'b0;
    wait_init("reinit");
    ones0 = 0;
    for (int k = 0; k < D; k++) begin
      cyc(1'b1, '0, '0, '0);
      ones0 += int'(bus.line_out[0]) + int'(bus.line_out[1]);
    end
    check("after_rst_zero", ones0, 0);
    check("after_rst_pos",  bus.bit_pos, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
